// File: rtl/alu_seq_pkg.sv
// Shared encodings for the alu instruction sequencer: instruction classes, branch
// conditions, ALU op constants, flag bit positions and the sequencer state enum.
package alu_seq_pkg;

  localparam logic [1:0] CL_ALU  = 2'b00;
  localparam logic [1:0] CL_BR   = 2'b01;
  localparam logic [1:0] CL_NOP  = 2'b10;
  localparam logic [1:0] CL_HALT = 2'b11;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_N      = 2'b11;

  // op 000 is the "no instruction" code: the alu does not write back on it
  localparam logic [2:0] OP_NONE = 3'b000;

  // flags word layout is {C,V,Z,N}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_FLAGS  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/alu_seq_cond.sv
// Branch-condition evaluator: decides whether a BR instruction is taken from the
// condition field and the currently held {C,V,Z,N} flags.
module alu_seq_cond
  import alu_seq_pkg::*;
(
  input  logic [1:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_ALWAYS: taken = 1'b1;
      COND_Z:      taken = flags[FLAG_Z];
      COND_C:      taken = flags[FLAG_C];
      COND_N:      taken = flags[FLAG_N];
      default:     taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Instruction sequencer for the alu block: fetches from a 1-cycle sync program memory,
// issues ALU ops for one cycle, captures the alu's registered flags and runs branches.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int START_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [PC_W-1:0] prog_addr,
  output logic            prog_rd,
  input  logic [15:0]     prog_data,
  output logic [2:0]      op,
  output logic [2:0]      a_addr,
  output logic [2:0]      b_addr,
  output logic [7:0]      const_o,
  output logic            cin,
  output logic            zero_in,
  input  logic            alu_cout,
  input  logic            alu_ovf,
  input  logic            alu_zero,
  input  logic            alu_neg,
  output logic [3:0]      flags
);

  localparam logic [PC_W-1:0] START = PC_W'(START_PC);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [3:0]      flags_q, flags_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            prog_rd_q, prog_rd_d;
  logic [2:0]      op_q, op_d;
  logic [2:0]      a_q, a_d;
  logic [2:0]      b_q, b_d;
  logic            cin_q, cin_d;
  logic            zero_in_q, zero_in_d;
  logic            taken;

  // Flags here are the ones held while the branch sits in DECODE.
  alu_seq_cond u_cond (
    .cond  (prog_data[13:12]),
    .flags (flags_q),
    .taken (taken)
  );

  assign pc_inc = pc_q + PC_W'(1);

  // Every output is a flop, so each value is computed one state ahead of where it shows.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flags_d   = flags_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    prog_rd_d = 1'b0;
    op_d      = OP_NONE;
    a_d       = 3'd0;
    b_d       = 3'd0;
    cin_d     = 1'b0;
    zero_in_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d      = START;
          busy_d    = 1'b1;
          prog_rd_d = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        case (prog_data[15:14])
          CL_ALU: begin
            op_d      = prog_data[13:11];
            a_d       = prog_data[10:8];
            b_d       = prog_data[7:5];
            cin_d     = prog_data[4] & flags_q[FLAG_C];
            zero_in_d = prog_data[3] ? flags_q[FLAG_Z] : 1'b1;
            state_d   = ST_EXEC;
          end
          CL_BR: begin
            pc_d      = taken ? prog_data[PC_W-1:0] : pc_inc;
            prog_rd_d = 1'b1;
            state_d   = ST_FETCH;
          end
          CL_NOP: begin
            pc_d      = pc_inc;
            prog_rd_d = 1'b1;
            state_d   = ST_FETCH;
          end
          default: begin
            done_d  = 1'b1;
            state_d = ST_HALT;
          end
        endcase
      end
      ST_EXEC: state_d = ST_FLAGS;
      ST_FLAGS: begin
        flags_d   = {alu_cout, alu_ovf, alu_zero, alu_neg};
        pc_d      = pc_inc;
        prog_rd_d = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= START;
      flags_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      prog_rd_q <= 1'b0;
      op_q      <= OP_NONE;
      a_q       <= 3'd0;
      b_q       <= 3'd0;
      cin_q     <= 1'b0;
      zero_in_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      prog_rd_q <= prog_rd_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      zero_in_q <= zero_in_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign prog_addr = pc_q;
  assign prog_rd   = prog_rd_q;
  assign op        = op_q;
  assign a_addr    = a_q;
  assign b_addr    = b_q;
  assign const_o   = 8'h00;
  assign cin       = cin_q;
  assign zero_in   = zero_in_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: an 8-bit-PC sequencer with a simple add-only alu and
// sync ROM, plus a 4-bit-PC instance for the PC wrap case.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, done, prog_rd, cin, zero_in;
  logic [7:0]  prog_addr, const_o;
  logic [15:0] prog_data;
  logic [2:0]  op, a_addr, b_addr;
  logic [3:0]  flags;
  logic        alu_cout = 1'b0, alu_ovf = 1'b0, alu_zero = 1'b0, alu_neg = 1'b0;

  logic        start4;
  logic        busy4, done4, prog_rd4, cin4, zero_in4;
  logic [3:0]  prog_addr4, flags4;
  logic [15:0] prog_data4;
  logic [2:0]  op4, a4, b4;
  logic [7:0]  const4;

  logic [15:0] rom  [256];
  logic [15:0] rom4 [16];
  logic [7:0]  regs [8] = '{8'h00, 8'hF0, 8'h20, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
  logic [8:0]  alu_sum;

  int total = 0;
  int bad   = 0;

  alu_seq #(.PC_W(8), .START_PC(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .prog_addr(prog_addr), .prog_rd(prog_rd), .prog_data(prog_data),
    .op(op), .a_addr(a_addr), .b_addr(b_addr), .const_o(const_o),
    .cin(cin), .zero_in(zero_in), .alu_cout(alu_cout), .alu_ovf(alu_ovf),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .flags(flags)
  );

  alu_seq #(.PC_W(4), .START_PC(15)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
    .prog_addr(prog_addr4), .prog_rd(prog_rd4), .prog_data(prog_data4),
    .op(op4), .a_addr(a4), .b_addr(b4), .const_o(const4),
    .cin(cin4), .zero_in(zero_in4), .alu_cout(1'b0), .alu_ovf(1'b0),
    .alu_zero(1'b0), .alu_neg(1'b0), .flags(flags4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (prog_rd) prog_data <= rom[prog_addr];
    if (prog_rd4) prog_data4 <= rom4[prog_addr4];
  end

  // Bench alu: any nonzero op adds r[a]+r[b]+cin into r[a] and registers the flags.
  always @(posedge clk) begin
    if (op != 3'b000) begin
      alu_sum = {1'b0, regs[a_addr]} + {1'b0, regs[b_addr]} + {8'd0, cin};
      regs[a_addr] <= alu_sum[7:0];
      alu_cout <= alu_sum[8];
      alu_ovf  <= (regs[a_addr][7] == regs[b_addr][7]) && (alu_sum[7] != regs[a_addr][7]);
      alu_zero <= (alu_sum[7:0] == 8'd0) && zero_in;
      alu_neg  <= alu_sum[7];
    end
  end

  function automatic logic [15:0] alu_i(input logic [2:0] o, input logic [2:0] a,
                                        input logic [2:0] b, input logic uc, input logic cz);
    return {2'b00, o, a, b, uc, cz, 3'b000};
  endfunction

  function automatic logic [15:0] br_i(input logic [1:0] c, input logic [7:0] t);
    return {2'b01, c, 4'b0000, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic wait_fetch(input logic [7:0] addr, input string tag);
    int n = 0;
    while (!prog_rd && n < 12) begin
      step();
      n++;
    end
    check({tag, "_rd"}, 16'(prog_rd), 16'd1);
    check(tag, 16'(prog_addr), 16'(addr));
    step();
  endtask

  task automatic wait_exec(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                           input logic c, input logic z, input string tag);
    int n = 0;
    while (op == 3'b000 && n < 12) begin
      step();
      n++;
    end
    check(tag, 16'({op, a_addr, b_addr, cin, zero_in}), 16'({o, a, b, c, z}));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 12) begin
      step();
      n++;
    end
    check({tag, "_done"}, 16'(done), 16'd1);
    check({tag, "_busy"}, 16'(busy), 16'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
    for (int i = 0; i < 16; i++) rom4[i] = 16'hC000;
    rom[0]    = alu_i(3'b111, 3'd1, 3'd2, 1'b0, 1'b0);
    rom[1]    = alu_i(3'b111, 3'd5, 3'd6, 1'b1, 1'b0);
    rom[2]    = alu_i(3'b111, 3'd5, 3'd6, 1'b0, 1'b0);
    rom[3]    = br_i(2'b01, 8'h10);
    rom[4]    = alu_i(3'b111, 3'd3, 3'd4, 1'b0, 1'b0);
    rom[5]    = br_i(2'b01, 8'h10);
    rom[8'h10] = 16'hC000;
    rom4[15]  = 16'h8000;
    rom4[0]   = 16'hC000;
    rst_n = 1'b0;
    start = 1'b0;
    start4 = 1'b0;
    step();
    step();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_prog_rd", 16'(prog_rd), 16'd0);
    check("rst_alu_if", 16'({op, a_addr, b_addr, cin, zero_in}), 16'h0001);
    check("rst_const", 16'(const_o), 16'h0000);
    check("rst_flags", 16'(flags), 16'h0000);
    check("rst_pc", 16'(prog_addr), 16'h0000);
    rst_n = 1'b1;
    step();

    // Run 1: ALU ops, carry chaining, Z branch not taken then taken, HALT
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_fetch", 16'({busy, prog_rd, prog_addr}), 16'h0300);
    wait_exec(3'b111, 3'd1, 3'd2, 1'b0, 1'b1, "exec0");
    step();
    check("flags_state_op", 16'(op), 16'd0);
    step();
    check("flags_add_carry", 16'(flags), 16'b1000);
    wait_exec(3'b111, 3'd5, 3'd6, 1'b1, 1'b1, "exec1_cin1");
    step();
    step();
    check("flags_exec1", 16'(flags), 16'b0000);
    wait_exec(3'b111, 3'd5, 3'd6, 1'b0, 1'b1, "exec2_cin0");
    step();
    step();
    wait_fetch(8'h03, "fetch_br_nt");
    start = 1'b1;
    step();
    start = 1'b0;
    wait_fetch(8'h04, "br_not_taken");
    wait_exec(3'b111, 3'd3, 3'd4, 1'b0, 1'b1, "exec_zero");
    step();
    step();
    check("flags_zero", 16'(flags), 16'b0010);
    wait_fetch(8'h05, "fetch_br_t");
    wait_fetch(8'h10, "br_taken");
    wait_done("halt1");
    check("halt1_pc", 16'(prog_addr), 16'h0010);
    step();
    check("halt1_after", 16'({busy, done}), 16'd0);

    // Run 2: NOPs then HALT at 3; start during the done cycle is ignored
    rom[0] = 16'h8000;
    rom[1] = 16'h8000;
    rom[2] = 16'h8000;
    rom[3] = 16'hC000;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_fetch(8'h00, "nop0");
    wait_fetch(8'h01, "nop1");
    wait_fetch(8'h02, "nop2");
    wait_fetch(8'h03, "halt_at3");
    wait_done("halt2");
    check("halt2_pc", 16'(prog_addr), 16'h0003);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_on_done", 16'({busy, done, prog_rd}), 16'd0);
    step();
    check("idle_after_done", 16'({busy, prog_rd}), 16'd0);
    check("flags_kept", 16'(flags), 16'b0010);

    // Run 3: reset in the middle of EXEC
    rom[0] = 16'h8000;
    rom[1] = alu_i(3'b111, 3'd1, 3'd2, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_exec(3'b111, 3'd1, 3'd2, 1'b0, 1'b1, "exec_pre_rst");
    rst_n = 1'b0;
    #1;
    check("midrst_alu_if", 16'({op, cin, zero_in}), 16'h0001);
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_flags", 16'(flags), 16'd0);
    check("midrst_pc", 16'(prog_addr), 16'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_quiet", 16'({busy, done, prog_rd}), 16'd0);
    end

    // PC_W=4: NOP at 4'hF wraps the next fetch to 4'h0
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    check("w4_fetch_f", 16'({prog_rd4, prog_addr4}), 16'h001F);
    step();
    step();
    check("w4_wrap_0", 16'({prog_rd4, prog_addr4}), 16'h0010);
    step();
    step();
    check("w4_halt_done", 16'({done4, busy4}), 16'h0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
